mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_sign_fix.sv | 13 +
 rtl/mdu_iter.sv | 165 ++++++++++++++++
 tb/tb_mdu_iter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and sizing helper for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; combinational, zero latency, no flow control.
// Used both to take operand magnitudes and to restore result signs.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: one bit per cycle, Done WIDTH+1 edges after an accepted Start.
// Start is ignored while Busy; no queuing. MDU_EARLY_OUT_EN lets trivial ops skip CALC.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [3:0]       S,
    input  logic             Signed,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result2,
    output logic             DivZero
);

    localparam int CW = clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_reg;
    logic               op_div;
    logic               x_neg_q;
    logic               y_neg_q;
    logic               dz_q;

    logic               accept;
    logic               step;
    logic               finish;
    logic               is_op;
    logic               last;
    logic               go_fix;
    logic               x_neg;
    logic               y_neg;
    logic [WIDTH-1:0]   abs_x;
    logic [WIDTH-1:0]   abs_y;
    logic [2*WIDTH-1:0] acc_init;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign is_op = (S == OP_MUL) || (S == OP_DIV);
    assign last  = (cnt == CW'(WIDTH - 1));
    assign x_neg = Signed & X[WIDTH-1];
    assign y_neg = Signed & Y[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_x (.value(X), .neg(x_neg), .fixed(abs_x));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_y (.value(Y), .neg(y_neg), .fixed(abs_y));

`ifdef MDU_EARLY_OUT_EN
    // Trivial ops preload the final magnitudes so FIX only has to apply signs.
    logic mul_triv;
    logic div_triv;
    assign mul_triv = (S == OP_MUL) && ((X == '0) || (Y == '0));
    assign div_triv = (S == OP_DIV) && ((Y == '0) || (abs_x < abs_y));
    assign go_fix   = mul_triv || div_triv;
    assign acc_init = mul_triv ? '0 :
                      div_triv ? {abs_x, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, abs_x};
`else
    assign go_fix   = 1'b0;
    assign acc_init = {{WIDTH{1'b0}}, abs_x};
`endif

    // Multiply: acc = {partial, remaining multiplier bits of |X|}, addend |Y|.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient bits}.
    assign trial    = acc[2*WIDTH-1:WIDTH-1];
    assign ge       = trial >= {1'b0, b_reg};
    assign diff     = trial[WIDTH-1:0] - b_reg;
    assign div_next = {(ge ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .neg(x_neg_q ^ y_neg_q), .fixed(prod_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .neg(x_neg_q ^ y_neg_q), .fixed(quo_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(x_neg_q), .fixed(rem_fixed));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start && is_op) state_nxt = go_fix ? FIX : CALC;
            CALC:    if (last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        Busy   = (state != IDLE);
        case (state)
            IDLE:    accept = Start && is_op;
            CALC:    step   = 1'b1;
            FIX:     finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            b_reg   <= '0;
            op_div  <= 1'b0;
            x_neg_q <= 1'b0;
            y_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            Done    <= 1'b0;
            Result  <= '0;
            Result2 <= '0;
            DivZero <= 1'b0;
        end else begin
            Done <= finish;
            if (accept) begin
                cnt     <= '0;
                acc     <= acc_init;
                b_reg   <= abs_y;
                op_div  <= (S == OP_DIV);
                x_neg_q <= x_neg;
                y_neg_q <= y_neg;
                dz_q    <= (S == OP_DIV) && (Y == '0);
            end
            if (step) begin
                cnt <= cnt + 1'b1;
                acc <= op_div ? div_next : mul_next;
            end
            if (finish) begin
                if (op_div) begin
                    Result  <= dz_q ? {WIDTH{1'b1}} : quo_fixed;
                    Result2 <= rem_fixed;
                    DivZero <= dz_q;
                end else begin
                    Result  <= prod_fixed[WIDTH-1:0];
                    Result2 <= prod_fixed[2*WIDTH-1:WIDTH];
                    DivZero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table plus hand sequences for overlap, back-to-back and reset abort.
module tb_mdu_iter;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [3:0]  S;
    logic        Signed;
    logic [31:0] X;
    logic [31:0] Y;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] Result2;
    logic        DivZero;

    int n_checks;
    int n_fail;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .S(S), .Signed(Signed), .X(X), .Y(Y),
        .Busy(Busy), .Done(Done), .Result(Result), .Result2(Result2), .DivZero(DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic        triv;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op; lat = edges after the accepting edge until Done is seen, -1 on timeout.
    task automatic run_op(input logic sg, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt);
        @(negedge clk);
        Start = 1'b1; S = op; Signed = sg; X = x; Y = y;
        @(posedge clk); #1;
        bcnt  = int'(Busy);
        Start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (Done) begin
                lat = i;
                break;
            end
            bcnt += int'(Busy);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        int first;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; Start = 1'b0; S = 4'd0; Signed = 1'b0; X = '0; Y = '0;

        vecs[0]  = '{1'b1, 4'd3, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd4, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd4, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd3, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 4'd4, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'd3, 32'd0,        32'hFFFFFFF7, 32'd0,        32'd0,        1'b0, 1'b1};
        vecs[11] = '{1'b0, 4'd3, 32'h00010000, 32'h00010000, 32'd0,        32'd1,        1'b0, 1'b0};

        #1;
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset Result", 64'(Result), 64'd0);
        check("reset Result2", 64'(Result2), 64'd0);
        check("reset DivZero", 64'(DivZero), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            int exp_lat;
            exp_lat = (EARLY && vecs[v].triv) ? 1 : 33;
            run_op(vecs[v].sg, vecs[v].op, vecs[v].x, vecs[v].y, lat, bcnt);
            check($sformatf("v%0d latency", v), 64'(lat), 64'(exp_lat));
            check($sformatf("v%0d busy cycles", v), 64'(bcnt), 64'(exp_lat));
            check($sformatf("v%0d Busy at Done", v), 64'(Busy), 64'd0);
            check($sformatf("v%0d Result", v), 64'(Result), 64'(vecs[v].lo));
            check($sformatf("v%0d Result2", v), 64'(Result2), 64'(vecs[v].hi));
            check($sformatf("v%0d DivZero", v), 64'(DivZero), 64'(vecs[v].dz));
        end

        // Mult 7*6 with a divide Start arriving at E5 while busy.
        @(negedge clk);
        Start = 1'b1; S = 4'd3; Signed = 1'b0; X = 32'd7; Y = 32'd6;
        @(posedge clk); #1;
        Start = 1'b0;
        dcnt = 0; first = -1;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk); #1;
            if (Done) begin
                dcnt++;
                if (first < 0) first = i;
            end
            Start = (i == 4);
            S = 4'd4; X = 32'd50; Y = 32'd5;
        end
        check("overlap done count", 64'(dcnt), 64'd1);
        check("overlap done edge", 64'(first), 64'd33);
        check("overlap Result", 64'(Result), 64'd42);
        check("overlap Result2", 64'(Result2), 64'd0);

        // Back-to-back: Start in the Done cycle.
        Start = 1'b1; S = 4'd4; Signed = 1'b0; X = 32'd100; Y = 32'd7;
        @(posedge clk); #1;
        Start = 1'b0;
        check("b2b Busy", 64'(Busy), 64'd1);
        check("b2b Done low", 64'(Done), 64'd0);
        check("b2b Result held", 64'(Result), 64'd42);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (Done) begin
                lat = i;
                break;
            end
        end
        check("b2b latency", 64'(lat), 64'd33);
        check("b2b Result", 64'(Result), 64'd14);
        check("b2b Result2", 64'(Result2), 64'd2);

        // Unsupported op code is ignored.
        @(negedge clk);
        Start = 1'b1; S = 4'd5; X = 32'd9; Y = 32'd9;
        @(posedge clk); #1;
        Start = 1'b0;
        check("bad op Busy", 64'(Busy), 64'd0);
        check("bad op Result held", 64'(Result), 64'd14);

        // Reset at E10 of a divide aborts it.
        @(negedge clk);
        Start = 1'b1; S = 4'd4; Signed = 1'b1; X = 32'hFFFFFF9C; Y = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort Busy", 64'(Busy), 64'd0);
        check("abort Done", 64'(Done), 64'd0);
        check("abort Result", 64'(Result), 64'd0);
        check("abort Result2", 64'(Result2), 64'd0);
        check("abort DivZero", 64'(DivZero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Done) dcnt++;
        end
        check("abort no Done", 64'(dcnt), 64'd0);
        run_op(1'b0, 4'd3, 32'd9, 32'd9, lat, bcnt);
        check("post-reset latency", 64'(lat), 64'd33);
        check("post-reset Result", 64'(Result), 64'd81);
        check("post-reset Result2", 64'(Result2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
